// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds prog_ctr for CPI cycles, then increments, branches, calls or returns.
// Optional return-address stack enabled by defining PC_STACK_EN.
module pc_sequencer #(
   parameter int             D         = 12,
   parameter int             CPI       = 6,
   parameter logic [D-1:0]   RESET_VEC = '0,
   parameter int             STK_DEPTH = 4,
   localparam int            PW        = (CPI > 1) ? $clog2(CPI) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          branch_abs,
   input  logic          branch_rel,
   input  logic [D-1:0]  target,
   input  logic [D-1:0]  offset,
   input  logic          call,
   input  logic          ret,
   output logic [D-1:0]  prog_ctr,
   output logic [PW-1:0] phase,
   output logic          instr_done,
   output logic          stk_empty,
   output logic          stk_full,
   output logic          stk_err
);

   localparam logic [PW-1:0] LAST_PHASE = PW'(CPI - 1);

   typedef enum logic [2:0] {
      OP_INC,
      OP_REL,
      OP_ABS,
      OP_CALL,
      OP_RET
   } op_t;

   op_t          op;
   logic [D-1:0] pc_inc;
   logic [D-1:0] pc_next;

   assign instr_done = (phase == LAST_PHASE) && !stall;
   assign pc_inc     = prog_ctr + D'(1);

   // Fixed priority: ret > call > branch_abs > branch_rel > increment.
   always_comb begin
      op = OP_INC;
      if (ret)             op = OP_RET;
      else if (call)       op = OP_CALL;
      else if (branch_abs) op = OP_ABS;
      else if (branch_rel) op = OP_REL;
   end

`ifdef PC_STACK_EN
   localparam int            SW      = $clog2(STK_DEPTH + 1);
   localparam int            AW      = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
   localparam logic [SW-1:0] SP_FULL = SW'(STK_DEPTH);

   logic [D-1:0]  stk_mem [STK_DEPTH];
   logic [SW-1:0] sp;
   logic [D-1:0]  stk_top;
   logic          push;
   logic          pop;
   logic          set_err;

   assign stk_empty = (sp == '0);
   assign stk_full  = (sp == SP_FULL);
   assign stk_top   = stk_mem[AW'(sp - 1'b1)];

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      pc_next = pc_inc;
      push    = 1'b0;
      pop     = 1'b0;
      set_err = 1'b0;
      unique case (op)
         OP_REL:  pc_next = prog_ctr + offset;
         OP_ABS:  pc_next = target;
         OP_CALL: begin
            pc_next = target;
            push    = !stk_full;
            set_err = stk_full;
         end
         OP_RET: begin
            if (!stk_empty) begin
               pc_next = stk_top;
               pop     = 1'b1;
            end else begin
               set_err = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp      <= '0;
         stk_err <= 1'b0;
      end else if (instr_done) begin
         if (push)     sp <= sp + 1'b1;
         else if (pop) sp <= sp - 1'b1;
         if (set_err)  stk_err <= 1'b1;
      end
   end

   // NOTE: stack storage is deliberately unreset; the pointer alone defines which entries are valid.
   always_ff @(posedge clk) begin
      if (instr_done && push) stk_mem[AW'(sp)] <= pc_inc;
   end
`else
   // Without storage, call is an absolute jump and ret an increment.
   always_comb begin
      pc_next = pc_inc;
      unique case (op)
         OP_REL:  pc_next = prog_ctr + offset;
         OP_ABS:  pc_next = target;
         OP_CALL: pc_next = target;
         OP_RET:  pc_next = pc_inc;
         default: ;
      endcase
   end

   assign stk_empty = 1'b1;
   assign stk_full  = (STK_DEPTH < 1);
   assign stk_err   = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase    <= '0;
         prog_ctr <= RESET_VEC;
      end else if (!stall) begin
         phase <= (phase == LAST_PHASE) ? '0 : phase + 1'b1;
         if (instr_done) prog_ctr <= pc_next;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver pushes model-predicted results, monitor checks each update.
// Model follows PC_STACK_EN the same way the design does.
module tb_pc_sequencer;

   localparam int          D         = 12;
   localparam int          CPI       = 6;
   localparam logic [11:0] RVEC      = 12'h010;
   localparam int          STK_DEPTH = 4;
   localparam int          MASK      = (1 << D) - 1;
   localparam int          PW        = $clog2(CPI);
`ifdef PC_STACK_EN
   localparam bit STACK_EN = 1'b1;
`else
   localparam bit STACK_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          stall;
   logic          branch_abs;
   logic          branch_rel;
   logic [D-1:0]  target;
   logic [D-1:0]  offset;
   logic          call;
   logic          ret;
   logic [D-1:0]  prog_ctr;
   logic [PW-1:0] phase;
   logic          instr_done;
   logic          stk_empty;
   logic          stk_full;
   logic          stk_err;

   pc_sequencer #(
      .D(D), .CPI(CPI), .RESET_VEC(RVEC), .STK_DEPTH(STK_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .stall(stall),
      .branch_abs(branch_abs), .branch_rel(branch_rel),
      .target(target), .offset(offset), .call(call), .ret(ret),
      .prog_ctr(prog_ctr), .phase(phase), .instr_done(instr_done),
      .stk_empty(stk_empty), .stk_full(stk_full), .stk_err(stk_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit ba, br, c, r;
      int tgt, off;
   } req_t;

   typedef struct {
      int pc;
      bit empty, full, err;
   } exp_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t exp_q[$];

   // Behavioural model state
   int   m_pc;
   int   m_stk[$];
   bit   m_err;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic req_t mk(bit ba, bit br, bit c, bit r, int tgt, int off);
      req_t q;
      q.ba = ba; q.br = br; q.c = c; q.r = r; q.tgt = tgt; q.off = off;
      return q;
   endfunction

   function automatic req_t rand_req();
      return mk($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)));
   endfunction

   task automatic apply(input req_t q);
      branch_abs = q.ba; branch_rel = q.br; call = q.c; ret = q.r;
      target = q.tgt[D-1:0]; offset = q.off[D-1:0];
   endtask

   // Predict the architectural effect of one instruction and queue it for the monitor.
   task automatic predict(input req_t q);
      exp_t e;
      if (q.r && STACK_EN) begin
         if (m_stk.size() > 0) m_pc = m_stk.pop_back();
         else begin m_pc = (m_pc + 1) & MASK; m_err = 1'b1; end
      end else if (q.r) begin
         m_pc = (m_pc + 1) & MASK;
      end else if (q.c) begin
         if (STACK_EN) begin
            if (m_stk.size() < STK_DEPTH) m_stk.push_back((m_pc + 1) & MASK);
            else m_err = 1'b1;
         end
         m_pc = q.tgt & MASK;
      end else if (q.ba) m_pc = q.tgt & MASK;
      else if (q.br)     m_pc = (m_pc + q.off) & MASK;
      else               m_pc = (m_pc + 1) & MASK;
      e.pc    = m_pc;
      e.empty = STACK_EN ? (m_stk.size() == 0) : 1'b1;
      e.full  = STACK_EN ? (m_stk.size() == STK_DEPTH) : 1'b0;
      e.err   = STACK_EN ? m_err : 1'b0;
      exp_q.push_back(e);
   endtask

   // mode 0: no stall, 1: random stalls, 2: four-cycle stall at phase 3
   task automatic run_instr(input req_t q, input int mode);
      int  n  = 0;
      int  sc = 0;
      bit  s;
      predict(q);
      while (n < CPI) begin
         if (n == CPI - 1) apply(q);
         else              apply(rand_req());
         s = 1'b0;
         if (mode == 1)      s = (sc < 3) && ($urandom_range(0, 4) == 0);
         else if (mode == 2) s = (n == 3) && (sc < 4);
         if (s) sc++;
         stall = s;
         @(posedge clk); #1;
         if (!s) n++;
      end
      stall = 1'b0;
      apply(mk(0, 0, 0, 0, 0, 0));
   endtask

   task automatic reset_and_check(input string tag);
      reset = 1'b0;
      exp_q.delete();
      m_pc = RVEC; m_stk.delete(); m_err = 1'b0;
      #1;
      check({tag, "_pc"},     prog_ctr,  RVEC);
      check({tag, "_phase"},  phase,     0);
      check({tag, "_empty"},  stk_empty, 1);
      check({tag, "_full"},   stk_full,  0);
      check({tag, "_err"},    stk_err,   0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   // Monitor: tracks phase and the committed PC; pops an expectation after each update edge.
   initial begin : monitor
      int  exp_phase = 0;
      int  cur_pc    = RVEC;
      bit  pend      = 1'b0;
      bit  exp_done;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            exp_phase = 0; cur_pc = RVEC; pend = 1'b0;
         end else begin
            if (pend) begin
               pend = 1'b0;
               if (exp_q.size() == 0) check("scoreboard_underrun", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  cur_pc = e.pc;
                  check("upd_empty", stk_empty, e.empty);
                  check("upd_full",  stk_full,  e.full);
                  check("upd_err",   stk_err,   e.err);
               end
            end
            exp_done = (exp_phase == CPI - 1) && !stall;
            check("prog_ctr",   prog_ctr,   cur_pc);
            check("phase",      phase,      exp_phase);
            check("instr_done", instr_done, exp_done);
            if (exp_done) pend = 1'b1;
            if (!stall) exp_phase = (exp_phase + 1) % CPI;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin : driver
      reset = 1'b0; stall = 1'b0;
      apply(mk(0, 0, 0, 0, 0, 0));
      m_pc = RVEC; m_err = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pc",    prog_ctr,  RVEC);
      check("rst_phase", phase,     0);
      check("rst_empty", stk_empty, 1);
      check("rst_full",  stk_full,  0);
      check("rst_err",   stk_err,   0);
      reset = 1'b1;

      // Plain increments from the reset vector
      repeat (3) run_instr(mk(0, 0, 0, 0, 0, 0), 0);

      // Absolute, negative relative and wrap-around increment
      run_instr(mk(1, 0, 0, 0, 12'h3A0, 0), 0);
      run_instr(mk(1, 0, 0, 0, 12'h005, 0), 0);
      run_instr(mk(0, 1, 0, 0, 0, 12'hFFE), 0);
      run_instr(mk(1, 0, 0, 0, 12'hFFF, 0), 0);
      run_instr(mk(0, 0, 0, 0, 0, 0), 0);

      // Stall held for four cycles at phase 3
      run_instr(mk(0, 0, 0, 0, 0, 0), 2);

      // Five nested calls (one overflows) then four returns
      run_instr(mk(1, 0, 0, 0, 12'h100, 0), 0);
      for (int i = 0; i < 5; i++) run_instr(mk(0, 0, 1, 0, 12'h101 + i, 0), 0);
      repeat (4) run_instr(mk(0, 0, 0, 1, 0, 0), 0);

      // Reset mid-instruction while the stack holds entries
      run_instr(mk(0, 0, 1, 0, 12'h200, 0), 0);
      run_instr(mk(0, 0, 1, 0, 12'h300, 0), 0);
      apply(mk(0, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      #1;
      check("pre_rst_phase", phase, 2);
      reset_and_check("midrst");

      // Return on empty stack, then call beats branch_abs
      run_instr(mk(1, 0, 0, 0, 12'h020, 0), 0);
      run_instr(mk(0, 0, 0, 1, 0, 0), 0);
      run_instr(mk(1, 0, 1, 0, 12'h040, 0), 0);
      run_instr(mk(0, 0, 0, 1, 0, 0), 0);

      // Randomised traffic with random stalls
      for (int i = 0; i < 200; i++) run_instr(rand_req(), 1);

      repeat (3) @(posedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
